// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch port: the fetch stage is master, the memory is slave.
interface if_fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
   modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, variable-latency fetch with hold/redirect.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   if_fetch_stage_if.master imem,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic [31:0] if_inst
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_bubble,
   output logic [31:0] perf_hold
`endif
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t      state, state_next;
   logic [31:0] pc;
   logic [31:0] hold_inst;
   logic        redir_pend;
   logic [31:0] redir_tgt;
   logic [31:0] sel_tgt;
   logic [31:0] npc_raw;
   logic [31:0] npc;
   logic        advance;
   logic        hold_load;

   always_comb begin
      sel_tgt = 32'h0000_0000;
      case (pcsource)
         2'b01:   sel_tgt = bpc;
         2'b10:   sel_tgt = rpc;
         2'b11:   sel_tgt = jpc;
         default: sel_tgt = 32'h0000_0000;
      endcase
   end

   // A live redirect from ID beats one captured while the PC was frozen.
   always_comb begin
      if (pcsource != 2'b00)
         npc_raw = sel_tgt;
      else if (redir_pend)
         npc_raw = redir_tgt;
      else
         npc_raw = pc + 32'd4;
      npc = {npc_raw[31:2], 2'b00};
   end

   always_comb begin
      state_next    = state;
      imem.imem_req = 1'b0;
      if_inst       = NOP_INST;
      advance       = 1'b0;
      hold_load     = 1'b0;
      case (state)
         FETCH: begin
            imem.imem_req = 1'b1;
            if (imem.imem_ready) begin
               if_inst = imem.imem_rdata;
               if (stall) begin
                  hold_load  = 1'b1;
                  state_next = HOLD;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         HOLD: begin
            if_inst = hold_inst;
            if (!stall) begin
               advance    = 1'b1;
               state_next = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase
      if (rst) begin
         imem.imem_req = 1'b0;
         if_inst       = NOP_INST;
      end
   end

   assign imem.imem_addr = pc;
   assign if_pc          = rst ? 32'h0000_0000 : pc;
   assign if_pc4         = rst ? 32'h0000_0000 : pc + 32'd4;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         hold_inst  <= NOP_INST;
         redir_pend <= 1'b0;
         redir_tgt  <= 32'h0000_0000;
      end else begin
         state <= state_next;
         if (hold_load)
            hold_inst <= imem.imem_rdata;
         if (advance) begin
            pc         <= npc;
            redir_pend <= 1'b0;
         end else if (pcsource != 2'b00) begin
            redir_pend <= 1'b1;
            redir_tgt  <= sel_tgt;
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_bubble <= 32'h0000_0000;
         perf_hold   <= 32'h0000_0000;
      end else begin
         if (state == FETCH && !imem.imem_ready)
            perf_bubble <= perf_bubble + 32'd1;
         if (state == HOLD)
            perf_hold <= perf_hold + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed test-plan steps then random cycles against a behavioural model.
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        stall;
   logic [1:0]  pcsource;
   logic [31:0] bpc, rpc, jpc;
   logic [31:0] if_pc, if_pc4, if_inst;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_bubble, perf_hold;
`endif

   if_fetch_stage_if imem ();

   if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .pcsource(pcsource),
      .bpc(bpc),
      .rpc(rpc),
      .jpc(jpc),
      .imem(imem.master),
      .if_pc(if_pc),
      .if_pc4(if_pc4),
      .if_inst(if_inst)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_bubble(perf_bubble),
      .perf_hold(perf_hold)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nVec = 0;
   int nMis = 0;

   // Reference model: the PC the stage is working on, whether it is parked on a word, and any saved redirect.
   logic [31:0] mPc;
   logic        mHolding;
   logic [31:0] mHoldWord;
   logic        mPend;
   logic [31:0] mTgt;
   logic [31:0] mBubble;
   logic [31:0] mHoldCnt;
   logic        curRdy;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h0000_0004)
         return 32'h2002_0005;
      return {a[15:0] ^ 16'h5A5A, ~a[31:16]} + 32'h0101_0001;
   endfunction

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp)
      else begin
         nMis++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      if (rst) begin
         check32("rstReq", {31'd0, imem.imem_req}, 32'd0);
         check32("rstInst", if_inst, NOP_INST);
         check32("rstPc4", if_pc4, 32'd0);
         check32("rstPc", if_pc, 32'd0);
      end else begin
         check32("addr", imem.imem_addr, mPc);
         check32("ifPc", if_pc, mPc);
         check32("ifPc4", if_pc4, mPc + 32'd4);
         check32("req", {31'd0, imem.imem_req}, {31'd0, !mHolding});
         if (mHolding)
            check32("holdInst", if_inst, mHoldWord);
         else
            check32("inst", if_inst, curRdy ? memWord(mPc) : NOP_INST);
`ifdef IF_PERF_CNT_EN
         check32("perfBubble", perf_bubble, mBubble);
         check32("perfHold", perf_hold, mHoldCnt);
`endif
      end
   endtask

   task automatic modelEdge(input logic r, input logic s, input logic [1:0] p,
                            input logic [31:0] b, input logic [31:0] rr, input logic [31:0] j,
                            input logic rdy);
      logic [31:0] target;
      logic [31:0] nxt;
      logic        moved;
      if (r) begin
         mPc = RESET_PC; mHolding = 1'b0; mHoldWord = NOP_INST;
         mPend = 1'b0; mTgt = 32'd0; mBubble = 32'd0; mHoldCnt = 32'd0;
         return;
      end
      target = (p == 2'b01) ? b : (p == 2'b10) ? rr : j;
      if (mHolding) mHoldCnt = mHoldCnt + 32'd1;
      else if (!rdy) mBubble = mBubble + 32'd1;
      moved = mHolding ? !s : (rdy && !s);
      if (moved) begin
         nxt = (p != 2'b00) ? target : (mPend ? mTgt : mPc + 32'd4);
         mPc = nxt & 32'hFFFF_FFFC;
         mPend = 1'b0;
         mHolding = 1'b0;
      end else begin
         if (p != 2'b00) begin
            mPend = 1'b1;
            mTgt = target;
         end
         if (!mHolding && rdy && s) begin
            mHolding = 1'b1;
            mHoldWord = memWord(mPc);
         end
      end
   endtask

   // Drive one cycle of inputs, check the settled outputs, then clock and advance the model.
   task automatic applyStimulus(input logic r, input logic s, input logic [1:0] p,
                                input logic [31:0] b, input logic [31:0] rr, input logic [31:0] j,
                                input logic rdy);
      rst = r; stall = s; pcsource = p; bpc = b; rpc = rr; jpc = j;
      curRdy = rdy;
      imem.imem_ready = rdy;
      imem.imem_rdata = rdy ? memWord(mPc) : 32'hDEAD_BEEF;
      #2;
      checkOutput();
      @(posedge clk);
      #1;
      modelEdge(r, s, p, b, rr, j, rdy);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      mPc = RESET_PC; mHolding = 1'b0; mHoldWord = NOP_INST; mPend = 1'b0;
      mTgt = 32'd0; mBubble = 32'd0; mHoldCnt = 32'd0; curRdy = 1'b0;
      rst = 1'b1; stall = 1'b0; pcsource = 2'b00; bpc = 32'd0; rpc = 32'd0; jpc = 32'd0;
      imem.imem_ready = 1'b0; imem.imem_rdata = 32'd0;
      @(posedge clk);
      #1;

      // Sequential zero-wait fetch.
      applyStimulus(1, 0, 2'b00, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);
         check32("seqAddr", imem.imem_addr, 32'(i * 4));
      end

      // Memory not ready at pc=8.
      applyStimulus(1, 0, 2'b00, 0, 0, 0, 0);
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);
      check32("waitAddr", imem.imem_addr, 32'h8);
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);
      check32("afterWaitAddr", imem.imem_addr, 32'hC);

      // Hold the word at pc=4 across a three-cycle stall.
      applyStimulus(1, 0, 2'b00, 0, 0, 0, 0);
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);
      applyStimulus(0, 1, 2'b00, 0, 0, 0, 1);
      check32("holdWord", if_inst, 32'h2002_0005);
      applyStimulus(0, 1, 2'b00, 0, 0, 0, 0);
      applyStimulus(0, 1, 2'b00, 0, 0, 0, 0);
      check32("holdReq", {31'd0, imem.imem_req}, 32'd0);
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);
      check32("releaseAddr", imem.imem_addr, 32'h8);

      // Branch captured during a wait at pc=16, delay-slot word still delivered.
      applyStimulus(0, 0, 2'b11, 0, 0, 32'h10, 1);
      applyStimulus(0, 0, 2'b01, 32'h40, 0, 0, 0);
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);
      check32("redirAddr", imem.imem_addr, 32'h40);

      // PC wrap and target alignment.
      applyStimulus(0, 0, 2'b11, 0, 0, 32'hFFFF_FFFC, 1);
      check32("wrapPc4", if_pc4, 32'h0);
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);
      check32("wrapAddr", imem.imem_addr, 32'h0);
      applyStimulus(0, 0, 2'b10, 0, 32'h0000_0123, 0, 1);
      check32("alignAddr", imem.imem_addr, 32'h120);

      // Reset while parked in HOLD with a pending redirect.
      applyStimulus(0, 1, 2'b00, 0, 0, 0, 1);
      applyStimulus(0, 1, 2'b01, 32'h80, 0, 0, 0);
      applyStimulus(1, 1, 2'b01, 32'h80, 0, 0, 0);
      check32("rstHoldAddr", imem.imem_addr, RESET_PC);
`ifdef IF_PERF_CNT_EN
      check32("rstBubble", perf_bubble, 32'd0);
      check32("rstHold", perf_hold, 32'd0);
`endif
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);
      check32("rstNoRedir", imem.imem_addr, RESET_PC);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic        r, s, rdy;
         logic [1:0]  p;
         r   = ($urandom_range(0, 49) == 0);
         s   = ($urandom_range(0, 3) == 0);
         p   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rdy = mHolding ? 1'b0 : ($urandom_range(0, 3) != 0);
         applyStimulus(r, s, p, $urandom, $urandom, $urandom, rdy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
